// File: rtl/toggle_assertion_monitor.sv
// Synthesizable bounded-delay implication checker: en&q sampled at edge t obliges z at
// edge t+DELAY (exact mode) or at some edge in t+1..t+DELAY (window mode), per channel.
module toggle_assertion_monitor #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DELAY = 2,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   chk_en,
  input  logic                                   clr,
  input  logic [NCH-1:0]                         mode,
  input  logic [NCH-1:0]                         en,
  input  logic [NCH-1:0]                         q,
  input  logic [NCH-1:0]                         z,
  output logic [NCH-1:0]                         fail_pulse,
  output logic [NCH-1:0]                         fail_sticky,
  output logic                                   fail_any,
  output logic [NCH*CNT_W-1:0]                   fail_cnt,
  output logic                                   first_valid,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_ch,
  output logic [TS_W-1:0]                        first_ts
);

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  // Bit k of pipe holds an obligation of age k+1.
  logic [DELAY-1:0] pipe_q [NCH];
  logic [DELAY-1:0] pipe_d [NCH];
  logic [NCH-1:0]   viol_c;

  logic [NCH-1:0]   pulse_q, pulse_d;
  logic [NCH-1:0]   sticky_q, sticky_d;
  logic             any_q, any_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  logic             first_valid_q, first_valid_d;
  logic [CH_W-1:0]  first_ch_q, first_ch_d;
  logic [TS_W-1:0]  first_ts_q, first_ts_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CH_W-1:0]  low_ch_c;

  // Obligation pipelines; a window-mode z discharges every younger entry.
  always_comb begin
    viol_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      pipe_d[i]    = '0;
      pipe_d[i][0] = chk_en & en[i] & q[i];
      for (int k = 1; k < int'(DELAY); k++) begin
        pipe_d[i][k] = pipe_q[i][k-1] & ~(mode[i] & z[i]);
      end
      viol_c[i] = pipe_q[i][DELAY-1] & ~z[i];
    end
  end

  // Pulse, sticky and any-fail reporting.
  always_comb begin
    pulse_d  = viol_c;
    sticky_d = (clr ? '0 : sticky_q) | viol_c;
    any_d    = |sticky_d;
  end

  // Saturating per-channel counters; clr and a violation together leave a count of one.
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      cnt_d[i] = clr ? '0 : cnt_q[i];
      if (viol_c[i] && (cnt_d[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_d[i] + CNT_W'(1);
      end
    end
  end

  // Lowest violating channel.
  always_comb begin
    low_ch_c = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (viol_c[i]) begin
        low_ch_c = CH_W'(i);
      end
    end
  end

  // First-fail record and free-running timestamp.
  always_comb begin
    first_valid_d = first_valid_q;
    first_ch_d    = first_ch_q;
    first_ts_d    = first_ts_q;
    ts_d          = ts_q + TS_W'(1);
    if (clr) begin
      first_valid_d = 1'b0;
      first_ch_d    = '0;
      first_ts_d    = '0;
    end
    if ((!first_valid_q || clr) && (|viol_c)) begin
      first_valid_d = 1'b1;
      first_ch_d    = low_ch_c;
      first_ts_d    = ts_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NCH); i++) begin
        pipe_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      pulse_q       <= '0;
      sticky_q      <= '0;
      any_q         <= 1'b0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      first_ts_q    <= '0;
      ts_q          <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        pipe_q[i] <= pipe_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      pulse_q       <= pulse_d;
      sticky_q      <= sticky_d;
      any_q         <= any_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
      first_ts_q    <= first_ts_d;
      ts_q          <= ts_d;
    end
  end

  // Pack counters onto the flat output bus.
  always_comb begin
    fail_cnt = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      fail_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign fail_pulse  = pulse_q;
  assign fail_sticky = sticky_q;
  assign fail_any    = any_q;
  assign first_valid = first_valid_q;
  assign first_ch    = first_ch_q;
  assign first_ts    = first_ts_q;

endmodule

// File: tb/tb_toggle_assertion_monitor.sv
// Bench for toggle_assertion_monitor: two instances (DELAY=2/CNT_W=8, DELAY=4/CNT_W=2)
// checked every cycle against an obligation-list model, plus literal spot values.
module tb_toggle_assertion_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       chk_en, clr;
  logic [3:0] mode, en, q, z;

  logic [3:0]  pulse_a, sticky_a, pulse_b, sticky_b;
  logic        any_a, any_b, fv_a, fv_b;
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;
  logic [1:0]  fch_a, fch_b;
  logic [15:0] fts_a, fts_b;

  int total = 0;
  int bad   = 0;
  int nxt   = 0;

  always #5 clk = ~clk;

  toggle_assertion_monitor #(.NCH(4), .DELAY(2), .CNT_W(8), .TS_W(16)) u_a (
    .clk(clk), .reset(rst_n), .chk_en(chk_en), .clr(clr), .mode(mode), .en(en), .q(q), .z(z),
    .fail_pulse(pulse_a), .fail_sticky(sticky_a), .fail_any(any_a), .fail_cnt(cnt_a),
    .first_valid(fv_a), .first_ch(fch_a), .first_ts(fts_a));

  toggle_assertion_monitor #(.NCH(4), .DELAY(4), .CNT_W(2), .TS_W(16)) u_b (
    .clk(clk), .reset(rst_n), .chk_en(chk_en), .clr(clr), .mode(mode), .en(en), .q(q), .z(z),
    .fail_pulse(pulse_b), .fail_sticky(sticky_b), .fail_any(any_b), .fail_cnt(cnt_b),
    .first_valid(fv_b), .first_ch(fch_b), .first_ts(fts_b));

  // Model: a list of outstanding obligations, each remembering the edge it was born at.
  typedef struct {
    int inst;
    int ch;
    int born;
  } ob_t;

  ob_t        obs[$];
  ob_t        keep[$];
  ob_t        nob;
  logic [3:0] m_viol   [2];
  logic [3:0] m_pulse  [2];
  logic [3:0] m_sticky [2];
  int         m_cnt    [2][4];
  bit         m_fv     [2];
  int         m_fch    [2];
  int         m_fts    [2];
  int         m_edge;

  function automatic int dly_of(input int n);
    return (n == 0) ? 2 : 4;
  endfunction

  function automatic int cmax_of(input int n);
    return (n == 0) ? 255 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs.delete();
      m_edge = 0;
      for (int n = 0; n < 2; n++) begin
        m_viol[n] = '0; m_pulse[n] = '0; m_sticky[n] = '0;
        m_fv[n] = 1'b0; m_fch[n] = 0; m_fts[n] = 0;
        for (int c = 0; c < 4; c++) m_cnt[n][c] = 0;
      end
    end else begin
      for (int n = 0; n < 2; n++) m_viol[n] = '0;
      keep.delete();
      foreach (obs[k]) begin
        if (m_edge - obs[k].born == dly_of(obs[k].inst)) begin
          if (!z[obs[k].ch]) m_viol[obs[k].inst][obs[k].ch] = 1'b1;
        end else if (!(mode[obs[k].ch] && z[obs[k].ch])) begin
          keep.push_back(obs[k]);
        end
      end
      obs = keep;
      for (int c = 0; c < 4; c++) begin
        if (chk_en && en[c] && q[c]) begin
          for (int n = 0; n < 2; n++) begin
            nob.inst = n; nob.ch = c; nob.born = m_edge;
            obs.push_back(nob);
          end
        end
      end
      for (int n = 0; n < 2; n++) begin
        m_pulse[n] = m_viol[n];
        if (clr) begin
          m_sticky[n] = '0; m_fv[n] = 1'b0; m_fch[n] = 0; m_fts[n] = 0;
          for (int c = 0; c < 4; c++) m_cnt[n][c] = 0;
        end
        m_sticky[n] = m_sticky[n] | m_viol[n];
        for (int c = 0; c < 4; c++)
          if (m_viol[n][c] && m_cnt[n][c] < cmax_of(n)) m_cnt[n][c]++;
        if (!m_fv[n] && m_viol[n] != 4'b0) begin
          m_fv[n]  = 1'b1;
          m_fts[n] = m_edge % 65536;
          for (int c = 3; c >= 0; c--) if (m_viol[n][c]) m_fch[n] = c;
        end
      end
      m_edge++;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("a.pulse",  32'(pulse_a),  32'(m_pulse[0]));
    chk("a.sticky", 32'(sticky_a), 32'(m_sticky[0]));
    chk("a.any",    32'(any_a),    32'(m_sticky[0] != 4'b0));
    chk("a.fv",     32'(fv_a),     32'(m_fv[0]));
    chk("a.fch",    32'(fch_a),    32'(m_fch[0]));
    chk("a.fts",    32'(fts_a),    32'(m_fts[0]));
    chk("b.pulse",  32'(pulse_b),  32'(m_pulse[1]));
    chk("b.sticky", 32'(sticky_b), 32'(m_sticky[1]));
    chk("b.any",    32'(any_b),    32'(m_sticky[1] != 4'b0));
    chk("b.fv",     32'(fv_b),     32'(m_fv[1]));
    chk("b.fch",    32'(fch_b),    32'(m_fch[1]));
    chk("b.fts",    32'(fts_b),    32'(m_fts[1]));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a.cnt%0d", i), 32'(cnt_a[i*8 +: 8]), 32'(m_cnt[0][i]));
      chk($sformatf("b.cnt%0d", i), 32'(cnt_b[i*2 +: 2]), 32'(m_cnt[1][i]));
    end
  end

  // Advance so that inputs assigned next are sampled at edge n; pulse inputs default low.
  task automatic to_edge(input int n);
    while (nxt < n) begin
      @(negedge clk);
      nxt++;
      en = '0; q = '0; z = '0; clr = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b1; chk_en = 1'b0; clr = 1'b0;
    mode = '0; en = '0; q = '0; z = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.a_any",  32'(any_a), 32'd0);
    chk("rst.b_fv",   32'(fv_b),  32'd0);
    chk("rst.a_cnt",  cnt_a,      32'd0);
    rst_n = 1'b1; chk_en = 1'b1; nxt = 0;

    // Exact, DELAY=2: z early but low at the check edge.
    to_edge(5);  en = 4'b0001; q = 4'b0001;
    to_edge(6);  z = 4'b0001;
    to_edge(8);
    chk("e7.a_pulse", 32'(pulse_a),  32'h1);
    chk("e7.a_stick", 32'(sticky_a), 32'h1);
    chk("e7.a_cnt0",  32'(cnt_a[7:0]), 32'd1);
    chk("e7.a_fch",   32'(fch_a),    32'd0);
    chk("e7.a_fts",   32'(fts_a),    32'd7);
    chk("e7.m_fts",   32'(m_fts[0]), 32'd7);
    to_edge(9);
    chk("e8.a_pulse", 32'(pulse_a), 32'h0);
    // Exact, z at the check edge.
    to_edge(10); en = 4'b0001; q = 4'b0001;
    to_edge(12); z = 4'b0001;
    to_edge(13);
    chk("e12.a_pulse", 32'(pulse_a), 32'h0);
    chk("e12.a_cnt0",  32'(cnt_a[7:0]), 32'd1);
    to_edge(16); clr = 1'b1;
    to_edge(17); mode = 4'hF;
    chk("e16.a_stick", 32'(sticky_a), 32'h0);
    chk("e16.a_fv",    32'(fv_a),     32'd0);

    // Window, DELAY=4.
    to_edge(20); en = 4'b0001; q = 4'b0001;
    to_edge(22); z = 4'b0001;
    to_edge(25);
    chk("e24.b_pulse", 32'(pulse_b),  32'h0);
    chk("e24.b_stick", 32'(sticky_b), 32'h0);
    to_edge(30); en = 4'b0001; q = 4'b0001;
    to_edge(35);
    chk("e34.b_pulse", 32'(pulse_b), 32'h1);
    chk("e34.b_cnt0",  32'(cnt_b[1:0]), 32'd1);
    chk("e34.b_fts",   32'(fts_b),   32'd34);
    to_edge(36);
    chk("e35.b_pulse", 32'(pulse_b), 32'h0);
    mode = 4'h0;

    // Back-to-back antecedents in exact mode; u_b counters saturate.
    for (int e = 40; e <= 44; e++) begin
      to_edge(e);
      if (e == 43) chk("e42.a_pulse", 32'(pulse_a), 32'h6);
      en = (e <= 42) ? 4'b0110 : 4'b0100;
      q  = en;
    end
    to_edge(46);
    chk("e45.a_pulse", 32'(pulse_a), 32'h4);
    chk("e45.a_cnt1",  32'(cnt_a[15:8]), 32'd3);
    to_edge(50);
    chk("e49.a_cnt2",  32'(cnt_a[23:16]), 32'd5);
    chk("e49.b_cnt2",  32'(cnt_b[5:4]),   32'd3);
    chk("e49.b_cnt1",  32'(cnt_b[3:2]),   32'd3);
    chk("e49.b_pulse", 32'(pulse_b),      32'h0);

    // Simultaneous violations, then clr together with a new one.
    to_edge(55); clr = 1'b1;
    to_edge(60); en = 4'b1010; q = 4'b1010;
    to_edge(63);
    chk("e62.a_pulse", 32'(pulse_a), 32'hA);
    chk("e62.a_fch",   32'(fch_a),   32'd1);
    chk("e62.a_fts",   32'(fts_a),   32'd62);
    to_edge(68); en = 4'b0100; q = 4'b0100;
    to_edge(70); clr = 1'b1;
    to_edge(71);
    chk("e70.a_stick", 32'(sticky_a),     32'h4);
    chk("e70.a_any",   32'(any_a),        32'd1);
    chk("e70.a_cnt2",  32'(cnt_a[23:16]), 32'd1);
    chk("e70.a_cnt1",  32'(cnt_a[15:8]),  32'd0);
    chk("e70.a_fch",   32'(fch_a),        32'd2);
    chk("e70.a_fts",   32'(fts_a),        32'd70);

    // Reset with obligations in flight.
    to_edge(80); en = 4'hF; q = 4'hF;
    to_edge(81); en = 4'hF; q = 4'hF;
    to_edge(82);
    #2 rst_n = 1'b0;
    #1 chk("rst2.a_stick", 32'(sticky_a), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; nxt = 0;
    to_edge(12);
    chk("post.a_stick", 32'(sticky_a), 32'h0);
    chk("post.b_stick", 32'(sticky_b), 32'h0);

    // chk_en low blocks new obligations.
    for (int e = 14; e <= 17; e++) begin
      to_edge(e); chk_en = 1'b0; en = 4'hF; q = 4'hF;
    end
    to_edge(18); chk_en = 1'b1;
    to_edge(25);
    chk("noen.a_stick", 32'(sticky_a), 32'h0);
    chk("noen.b_stick", 32'(sticky_b), 32'h0);
    chk("noen.b_fv",    32'(fv_b),     32'd0);

    // Mixed traffic with mode changes mid-obligation and periodic clr.
    for (int e = 26; e <= 90; e++) begin
      to_edge(e);
      chk_en = (e % 11) != 0;
      mode   = 4'(e >> 3);
      en     = 4'(e * 5);
      q      = 4'(e * 3 + 1);
      z      = 4'((e * 7) >> 2);
      clr    = (e % 23) == 0;
    end
    to_edge(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
